udp_header_builder: RTL and testbench

- Transmit-side counterpart of the UDP header parser. Takes a per-packet command (ports, payload length, checksum) and an 8-bit payload stream, and emits one 8-bit UDP datagram stream: 8 header bytes, big-endian, then the payload.
- The length field is computed internally as payload length + 8.
- Sits between the packet-assembly FSM and the IP/MAC transmit path.

---
 rtl/udp_header_builder.sv | 184 ++++++++++++++++++
 tb/tb_udp_header_builder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_header_builder.sv
// udp_header_builder
// Transmit-side UDP header builder. Accepts a per-packet command (ports,
// payload length, checksum), emits the 8-byte big-endian UDP header and then
// passes the payload stream straight through with no added latency. The
// length field is payload_len + 8. Frames whose pl_last disagrees with the
// commanded length are cut or drained, with a frame_err pulse.
//
// Optional build macro: UDP_TX_COUNT_EN adds the tx_pkt_count output, a
// 16-bit wrapping count of completed datagrams (handshakes carrying tx_last).
module udp_header_builder #(
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] payload_len,
    input  logic [15:0] checksum_in,
    input  logic [7:0]  pl_data,
    input  logic        pl_valid,
    input  logic        pl_last,
    output logic        pl_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic        busy,
    output logic        len_err,
    output logic        frame_err
`ifdef UDP_TX_COUNT_EN
    ,
    output logic [15:0] tx_pkt_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        DRAIN
    } state_t;

    state_t      state;
    logic [15:0] src_reg;
    logic [15:0] dst_reg;
    logic [15:0] len_reg;
    logic [15:0] csum_reg;
    logic [15:0] rem;
    logic [2:0]  hdr_idx;
    logic [7:0]  hdr_byte;
    logic        tx_hs;
    logic        pl_hs;

    assign tx_hs = tx_valid & tx_ready;
    assign pl_hs = pl_valid & pl_ready;

    // Select the current header byte, big-endian field order.
    always_comb begin
        hdr_byte = '0;
        case (hdr_idx)
            3'd0: hdr_byte = src_reg[15:8];
            3'd1: hdr_byte = src_reg[7:0];
            3'd2: hdr_byte = dst_reg[15:8];
            3'd3: hdr_byte = dst_reg[7:0];
            3'd4: hdr_byte = len_reg[15:8];
            3'd5: hdr_byte = len_reg[7:0];
            3'd6: hdr_byte = csum_reg[15:8];
            3'd7: hdr_byte = csum_reg[7:0];
            default: hdr_byte = '0;
        endcase
    end

    // Stream outputs decoded from state; payload is a combinational pass-through.
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        tx_data   = '0;
        tx_valid  = 1'b0;
        tx_last   = 1'b0;
        pl_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            HEADER: begin
                tx_data  = hdr_byte;
                tx_valid = 1'b1;
                tx_last  = (hdr_idx == 3'd7) && (rem == 16'd0);
            end
            PAYLOAD: begin
                tx_data  = pl_data;
                tx_valid = pl_valid;
                pl_ready = tx_ready;
                tx_last  = pl_valid & ((rem == 16'd1) | pl_last);
            end
            DRAIN: begin
                pl_ready = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Frame sequencing, command capture and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            csum_reg  <= '0;
            rem       <= '0;
            hdr_idx   <= '0;
            len_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            len_err   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (payload_len > MAX_PAYLOAD) begin
                            len_err <= 1'b1;
                        end else begin
                            src_reg  <= src_port;
                            dst_reg  <= dst_port;
                            len_reg  <= payload_len + 16'd8;
                            csum_reg <= checksum_in;
                            rem      <= payload_len;
                            hdr_idx  <= '0;
                            state    <= HEADER;
                        end
                    end
                end
                HEADER: begin
                    if (tx_hs) begin
                        if (hdr_idx == 3'd7) begin
                            state <= (rem == 16'd0) ? IDLE : PAYLOAD;
                        end else begin
                            hdr_idx <= hdr_idx + 3'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    // tx and pl handshakes coincide here since pl_ready mirrors tx_ready.
                    if (tx_hs) begin
                        rem <= rem - 16'd1;
                        if (pl_last) begin
                            state <= IDLE;
                            if (rem != 16'd1) begin
                                frame_err <= 1'b1;
                            end
                        end else if (rem == 16'd1) begin
                            state     <= DRAIN;
                            frame_err <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pl_hs && pl_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UDP_TX_COUNT_EN
    // Count datagrams that completed with a tx_last handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_pkt_count <= '0;
        end else if (tx_hs && tx_last) begin
            tx_pkt_count <= tx_pkt_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_udp_header_builder.sv
// Directed testbench for udp_header_builder. Inputs are driven on the falling
// edge and outputs sampled 1 ns later, well away from the rising edge.
module tb_udp_header_builder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] payload_len;
    logic [15:0] checksum_in;
    logic [7:0]  pl_data;
    logic        pl_valid;
    logic        pl_last;
    logic        pl_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic        busy;
    logic        len_err;
    logic        frame_err;
`ifdef UDP_TX_COUNT_EN
    logic [15:0] tx_pkt_count;
`endif

    always #5 clk = ~clk;

    udp_header_builder #(.MAX_PAYLOAD(16'd1472)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .src_port    (src_port),
        .dst_port    (dst_port),
        .payload_len (payload_len),
        .checksum_in (checksum_in),
        .pl_data     (pl_data),
        .pl_valid    (pl_valid),
        .pl_last     (pl_last),
        .pl_ready    (pl_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .len_err     (len_err),
        .frame_err   (frame_err)
`ifdef UDP_TX_COUNT_EN
        ,
        .tx_pkt_count(tx_pkt_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Payload to feed, and what the stream produced.
    logic [7:0] pl_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         last_pos;
    bit         stall_mode;
    int         last_cnt;
    int         last_idx;
    int         fe_cnt;
    int         drain_cnt;
    bit         pl_ready_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input logic [15:0] c);
        @(negedge clk);
        cmd_valid   = 1'b1;
        src_port    = s;
        dst_port    = d;
        payload_len = l;
        checksum_in = c;
        #1;
        chk("cmd_ready_at_cmd", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_stream(input int budget);
        int         pi = 0;
        int         cyc = 0;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        bit         done = 1'b0;
        got_q.delete();
        last_cnt      = 0;
        last_idx      = -1;
        fe_cnt        = 0;
        drain_cnt     = 0;
        pl_ready_seen = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (pi < pl_q.size()) begin
                pl_valid = 1'b1;
                pl_data  = pl_q[pi];
                pl_last  = (pi == last_pos);
            end else begin
                pl_valid = 1'b0;
                pl_data  = '0;
                pl_last  = 1'b0;
            end
            tx_ready = stall_mode ? ((cyc % 2) == 0) : 1'b1;
            #1;
            if (prev_stall) chk("stall_hold", {24'd0, tx_data}, {24'd0, prev_data});
            prev_stall = tx_valid & !tx_ready;
            prev_data  = tx_data;
            if (pl_ready) pl_ready_seen = 1'b1;
            if (frame_err) fe_cnt++;
            if (tx_valid && tx_ready) begin
                got_q.push_back(tx_data);
                if (tx_last) begin
                    last_cnt++;
                    last_idx = got_q.size() - 1;
                end
            end
            if (pl_valid && pl_ready) begin
                if (!tx_valid) drain_cnt++;
                pi++;
            end
            cyc++;
            if (!busy) begin
                done = 1'b1;
            end else if (cyc >= budget) begin
                chk("stream_timeout_busy", {31'd0, busy}, 32'd0);
                done = 1'b1;
            end
        end
        pl_valid = 1'b0;
        pl_last  = 1'b0;
        pl_data  = '0;
        tx_ready = 1'b1;
    endtask

    task automatic check_frame(input string name);
        chk($sformatf("%s_nbytes", name), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_b%0d", name, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    endtask

    initial begin
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        src_port    = '0;
        dst_port    = '0;
        payload_len = '0;
        checksum_in = '0;
        pl_data     = '0;
        pl_valid    = 1'b0;
        pl_last     = 1'b0;
        tx_ready    = 1'b1;
        stall_mode  = 1'b0;
        last_pos    = -1;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_tx_valid",  {31'd0, tx_valid},  32'd0);
        chk("rst_tx_last",   {31'd0, tx_last},   32'd0);
        chk("rst_pl_ready",  {31'd0, pl_ready},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_len_err",   {31'd0, len_err},   32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_tx_data",   {24'd0, tx_data},   32'd0);
`ifdef UDP_TX_COUNT_EN
        chk("rst_count", {16'd0, tx_pkt_count}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, tx_ready held high
        send_cmd(16'h1234, 16'h0050, 16'd4, 16'hBEEF);
        pl_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        last_pos = 3;
        run_stream(100);
        exp_q = '{8'h12, 8'h34, 8'h00, 8'h50, 8'h00, 8'h0C, 8'hBE, 8'hEF,
                  8'hAA, 8'hBB, 8'hCC, 8'hDD};
        check_frame("basic");
        chk("basic_last_cnt", last_cnt, 32'd1);
        chk("basic_last_idx", last_idx, 32'd11);
        chk("basic_frame_err", fe_cnt, 32'd0);
        chk("basic_busy_after", {31'd0, busy}, 32'd0);

        // Same frame with tx_ready toggling every cycle
        send_cmd(16'h1234, 16'h0050, 16'd4, 16'hBEEF);
        stall_mode = 1'b1;
        run_stream(200);
        stall_mode = 1'b0;
        check_frame("stall");
        chk("stall_last_cnt", last_cnt, 32'd1);
        chk("stall_last_idx", last_idx, 32'd11);

        // Zero-length payload: header only, last on checksum low byte
        send_cmd(16'h0400, 16'h1F90, 16'd0, 16'h1357);
        pl_q = '{8'h5A};
        last_pos = 0;
        run_stream(100);
        pl_q.delete();
        exp_q = '{8'h04, 8'h00, 8'h1F, 8'h90, 8'h00, 8'h08, 8'h13, 8'h57};
        check_frame("zero");
        chk("zero_last_idx", last_idx, 32'd7);
        chk("zero_pl_ready", {31'd0, pl_ready_seen}, 32'd0);

        // Oversized command rejected
        send_cmd(16'h0001, 16'h0002, 16'd1500, 16'h0003);
        @(negedge clk);
        #1;
        chk("oversize_len_err",   {31'd0, len_err},   32'd1);
        chk("oversize_tx_valid",  {31'd0, tx_valid},  32'd0);
        chk("oversize_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("oversize_busy",      {31'd0, busy},      32'd0);
        @(negedge clk);
        #1;
        chk("oversize_pulse_end", {31'd0, len_err},   32'd0);
        chk("oversize_tx_valid2", {31'd0, tx_valid},  32'd0);

        // Short frame: pl_last on 2nd of 4 expected bytes
        send_cmd(16'hA001, 16'h0035, 16'd4, 16'h0000);
        pl_q = '{8'h11, 8'h22};
        last_pos = 1;
        run_stream(100);
        exp_q = '{8'hA0, 8'h01, 8'h00, 8'h35, 8'h00, 8'h0C, 8'h00, 8'h00,
                  8'h11, 8'h22};
        check_frame("short");
        chk("short_last_idx", last_idx, 32'd9);
        chk("short_frame_err", fe_cnt, 32'd1);
        chk("short_busy_after", {31'd0, busy}, 32'd0);

        // Long frame: 2 expected, pl_last on 5th; bytes 3-5 drained
        send_cmd(16'h0007, 16'h0008, 16'd2, 16'hFFFF);
        pl_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        last_pos = 4;
        run_stream(100);
        exp_q = '{8'h00, 8'h07, 8'h00, 8'h08, 8'h00, 8'h0A, 8'hFF, 8'hFF,
                  8'h61, 8'h62};
        check_frame("long");
        chk("long_last_cnt", last_cnt, 32'd1);
        chk("long_last_idx", last_idx, 32'd9);
        chk("long_frame_err", fe_cnt, 32'd1);
        chk("long_drained", drain_cnt, 32'd3);

`ifdef UDP_TX_COUNT_EN
        chk("count_before_reset", {16'd0, tx_pkt_count}, 32'd5);
`endif

        // Reset asserted while header byte 3 is on the bus
        send_cmd(16'h1111, 16'h2222, 16'd1, 16'h3333);
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);
        #1;
        chk("midrst_byte3", {24'd0, tx_data}, 32'h22);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_valid",  {31'd0, tx_valid},  32'd0);
        chk("midrst_tx_last",   {31'd0, tx_last},   32'd0);
        chk("midrst_tx_data",   {24'd0, tx_data},   32'd0);
        chk("midrst_busy",      {31'd0, busy},      32'd0);
        chk("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_pl_ready",  {31'd0, pl_ready},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        send_cmd(16'h5555, 16'h6666, 16'd1, 16'h7777);
        pl_q = '{8'h9C};
        last_pos = 0;
        run_stream(100);
        exp_q = '{8'h55, 8'h55, 8'h66, 8'h66, 8'h00, 8'h09, 8'h77, 8'h77, 8'h9C};
        check_frame("postrst");
        chk("postrst_last_idx", last_idx, 32'd8);
`ifdef UDP_TX_COUNT_EN
        chk("postrst_count", {16'd0, tx_pkt_count}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
